// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: packet front-end that sequences load/char/eop strobes into the regex matcher bank.
// Define DPI_SEQ_STATS_EN to add the pkt_cnt/byte_cnt statistics outputs.
module dpi_stream_sequencer #(
    parameter int NUM_REGEX = 16,
    parameter int LOAD_GAP = 2,
    parameter int EOP_DRAIN = 3,
    parameter logic [NUM_REGEX-1:0] ENABLE_RST = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_vld,
    output logic                 pkt_rdy,
    input  logic                 pkt_sop,
    input  logic                 pkt_eop,
    input  logic [7:0]           pkt_data,
    input  logic [5:0]           pkt_stream_id,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [NUM_REGEX-1:0] cfg_wdata,
    input  logic                 seen_clr,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic                 load_state,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic [NUM_REGEX-1:0] enable,
`ifdef DPI_SEQ_STATS_EN
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          byte_cnt,
    output logic                 busy,
`else
    output logic                 busy,
`endif
    output logic                 protocol_err
);
    typedef enum logic [2:0] {IDLE, LOAD, GAP, STREAM, DRAIN, EOP} state_t;
    state_t state;
    logic [63:0] seen;
    logic [NUM_REGEX-1:0] en_tab [64];
    logic [7:0] cnt;
    logic first;
    logic acc;
    assign acc = pkt_vld & pkt_rdy & (state != IDLE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) en_tab[i] <= ENABLE_RST;
        end else if (cfg_we) begin
            en_tab[cfg_addr] <= cfg_wdata;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            seen <= '0;
            cnt <= '0;
            first <= 1'b0;
            pkt_rdy <= 1'b0;
            stream_id <= '0;
            new_stream_id <= 1'b0;
            load_state <= 1'b0;
            char_in <= '0;
            char_in_vld <= 1'b0;
            eop <= 1'b0;
            enable <= '0;
            busy <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            load_state <= 1'b0;
            eop <= 1'b0;
            char_in_vld <= acc;
            if (acc) char_in <= pkt_data;
            case (state)
                IDLE: begin
                    // a ready raised for a stray beat lasts one cycle so a following sop is only peeked
                    if (pkt_rdy) begin
                        pkt_rdy <= 1'b0;
                    end else if (pkt_vld && pkt_sop) begin
                        state <= LOAD;
                        busy <= 1'b1;
                        load_state <= 1'b1;
                        stream_id <= pkt_stream_id;
                        new_stream_id <= ~seen[pkt_stream_id];
                        enable <= en_tab[pkt_stream_id];
                        pkt_rdy <= (LOAD_GAP == 0);
                        first <= 1'b1;
                        cnt <= '0;
                    end else if (pkt_vld) begin
                        pkt_rdy <= 1'b1;
                        protocol_err <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= (LOAD_GAP > 1) ? GAP : STREAM;
                    pkt_rdy <= (LOAD_GAP <= 1);
                end
                GAP: begin
                    if (cnt == 8'(LOAD_GAP - 2)) begin
                        state <= STREAM;
                        pkt_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (cnt == 8'(EOP_DRAIN - 1)) begin
                        state <= EOP;
                        eop <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                EOP: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    seen[stream_id] <= 1'b1;
                end
                default: ;
            endcase
            if (acc) begin
                first <= 1'b0;
                if (pkt_sop && !first) protocol_err <= 1'b1;
                if (pkt_eop) begin
                    pkt_rdy <= 1'b0;
                    cnt <= '0;
                    state <= (EOP_DRAIN == 0) ? EOP : DRAIN;
                    eop <= (EOP_DRAIN == 0);
                end
            end
            if (seen_clr) seen <= '0;
        end
    end
`ifdef DPI_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            if (eop) pkt_cnt <= pkt_cnt + 32'd1;
            if (char_in_vld) byte_cnt <= byte_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: directed checks of the sequencer's strobe timing, stream tracking and enable table.
module tb_dpi_stream_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pkt_vld = 1'b0, pkt_rdy, pkt_sop = 1'b0, pkt_eop = 1'b0;
    logic [7:0] pkt_data = '0;
    logic [5:0] pkt_stream_id = '0;
    logic cfg_we = 1'b0;
    logic [5:0] cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic seen_clr = 1'b0;
    logic [5:0] stream_id;
    logic new_stream_id, load_state, char_in_vld, eop, busy, protocol_err;
    logic [7:0] char_in;
    logic [15:0] enable;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_c[$];
    logic new_b[$];
    logic [15:0] load_en[$];
    int eop_c[$];
    logic [15:0] eop_en[$];
    logic [7:0] ch[$];
    int ch_c[$];
    logic [7:0] txq[$];

    dpi_stream_sequencer dut (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_sop(pkt_sop),
        .pkt_eop(pkt_eop), .pkt_data(pkt_data), .pkt_stream_id(pkt_stream_id), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .seen_clr(seen_clr), .stream_id(stream_id),
        .new_stream_id(new_stream_id), .load_state(load_state), .char_in(char_in),
        .char_in_vld(char_in_vld), .eop(eop), .enable(enable), .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (load_state) begin
            load_c.push_back(cyc);
            new_b.push_back(new_stream_id);
            load_en.push_back(enable);
        end
        if (char_in_vld) begin
            ch.push_back(char_in);
            ch_c.push_back(cyc);
        end
        if (eop) begin
            eop_c.push_back(cyc);
            eop_en.push_back(enable);
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clr;
        load_c.delete(); new_b.delete(); load_en.delete();
        eop_c.delete(); eop_en.delete(); ch.delete(); ch_c.delete();
    endtask
    task automatic wait_hs;
        int t = 0;
        while (!pkt_rdy && t < 50) begin
            tick();
            t++;
        end
        chk("handshake_wait", 32'(t < 50), 1);
        tick();
    endtask
    task automatic wait_idle;
        int t = 0;
        while ((busy || pkt_rdy) && t < 100) begin
            tick();
            t++;
        end
        chk("idle_wait", 32'(t < 100), 1);
    endtask
    task automatic send(input logic [5:0] id, input bit bubble);
        for (int i = 0; i < txq.size(); i++) begin
            pkt_vld = 1'b1;
            pkt_sop = (i == 0);
            pkt_eop = (i == txq.size() - 1);
            pkt_data = txq[i];
            pkt_stream_id = id;
            wait_hs();
            pkt_vld = 1'b0;
            pkt_sop = 1'b0;
            pkt_eop = 1'b0;
            if (bubble && i != txq.size() - 1) tick();
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pkt_rdy", 32'(pkt_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_outputs", {load_state, char_in_vld, eop, new_stream_id, protocol_err}, 0);
        rst = 1'b0;
        tick();
        // new stream 5, then again as a known stream
        clr();
        txq = '{8'h61, 8'h62, 8'h63, 8'h64};
        send(6'd5, 1'b0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_stream_id", 32'(stream_id), 5);
        wait_idle();
        chk("t1_loads", load_c.size(), 1);
        chk("t1_new", 32'(new_b[0]), 1);
        chk("t1_nbytes", ch.size(), 4);
        chk("t1_bytes", {ch[0], ch[1], ch[2], ch[3]}, 32'h61626364);
        chk("t1_load_gap", ch_c[0] - load_c[0], 3);
        chk("t1_contig", ch_c[3] - ch_c[0], 3);
        chk("t1_eop_drain", eop_c[0] - ch_c[3], 3);
        chk("t1_enable", 32'(eop_en[0]), 32'hffff);
        chk("t1_perr", 32'(protocol_err), 0);
        clr();
        send(6'd5, 1'b0);
        wait_idle();
        chk("t1b_new", 32'(new_b[0]), 0);
        // back-to-back single-byte packets on stream 9
        clr();
        txq = '{8'h39};
        send(6'd9, 1'b0);
        send(6'd9, 1'b0);
        wait_idle();
        chk("t2_loads", load_c.size(), 2);
        chk("t2_eops", eop_c.size(), 2);
        chk("t2_spacing", 32'((load_c[1] - eop_c[0]) >= 2), 1);
        chk("t2_new0", 32'(new_b[0]), 1);
        chk("t2_new1", 32'(new_b[1]), 0);
        chk("t2_eop_drain", eop_c[0] - ch_c[0], 3);
        // seen_clr makes stream 9 new again
        seen_clr = 1'b1;
        tick();
        seen_clr = 1'b0;
        clr();
        send(6'd9, 1'b0);
        wait_idle();
        chk("seen_clr_new", 32'(new_b[0]), 1);
        // enable table write, and a write during LOAD that only the next packet sees
        cfg_we = 1'b1; cfg_addr = 6'd3; cfg_wdata = 16'h0001;
        tick();
        cfg_we = 1'b0;
        clr();
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b1; pkt_data = 8'h11; pkt_stream_id = 6'd3;
        tick();
        chk("t3_load", 32'(load_state), 1);
        chk("t3_enable_load", 32'(enable), 32'h0001);
        cfg_we = 1'b1; cfg_wdata = 16'h00f0;
        tick();
        cfg_we = 1'b0;
        wait_hs();
        pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
        wait_idle();
        chk("t3_enable_eop", 32'(eop_en[0]), 32'h0001);
        clr();
        send(6'd3, 1'b0);
        wait_idle();
        chk("t3_late_write", 32'(load_en[0]), 32'h00f0);
        clr();
        send(6'd4, 1'b0);
        wait_idle();
        chk("t3_other_id", 32'(load_en[0]), 32'hffff);
        // stray non-sop beat in IDLE
        clr();
        pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = 8'h55;
        tick();
        chk("t4_rdy", 32'(pkt_rdy), 1);
        chk("t4_perr", 32'(protocol_err), 1);
        tick();
        pkt_vld = 1'b0;
        chk("t4_rdy_drop", 32'(pkt_rdy), 0);
        tick();
        tick();
        chk("t4_no_load", load_c.size(), 0);
        chk("t4_no_char", ch.size(), 0);
        chk("t4_busy", 32'(busy), 0);
        // upstream bubbles every other cycle
        clr();
        txq = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        send(6'd7, 1'b1);
        wait_idle();
        chk("t5_nbytes", ch.size(), 6);
        chk("t5_first", 32'(ch[0]), 32'h10);
        chk("t5_last", 32'(ch[5]), 32'h65);
        for (int i = 1; i < 6; i++) chk("t5_gap", ch_c[i] - ch_c[i-1], 2);
        chk("t5_perr_sticky", 32'(protocol_err), 1);
        // reset mid-stream on a known stream
        clr();
        txq = '{8'h01};
        send(6'd5, 1'b0);
        wait_idle();
        clr();
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_data = 8'h77; pkt_stream_id = 6'd5;
        wait_hs();
        pkt_sop = 1'b0; pkt_data = 8'h78;
        wait_hs();
        chk("t6_pre_new", 32'(new_b[0]), 0);
        chk("t6_pre_vld", 32'(char_in_vld), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_strobes", {pkt_rdy, load_state, char_in_vld, eop, busy, protocol_err}, 0);
        chk("t6_rst_ids", {stream_id, enable, char_in}, 0);
        pkt_vld = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("t6_no_eop", eop_c.size(), 0);
        clr();
        txq = '{8'h02};
        send(6'd5, 1'b0);
        wait_idle();
        chk("t6_new_again", 32'(new_b[0]), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
